nonce_report_tx: RTL and testbench

Transmit side of the miner's host link. Takes golden nonces from the miner as single-cycle pulses and buffers them in a 2-entry FIFO. Serializes each nonce as a 5-byte UART frame (8N1) on a single output pin to the host. Sits between the miner's result output and the board TX pin; it is the counterpart of the host-to-miner work path.

---
 rtl/miner_pkg.sv | 30 +++
 rtl/nonce_fifo2.sv | 48 ++++
 rtl/nonce_report_tx.sv | 133 +++++++++++++
 tb/tb_nonce_report_tx.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared definitions for the miner's host-link blocks: serializer state
// encoding, frame geometry and the frame byte selector.
package miner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int         FRAME_BYTES       = 5;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Byte idx of a report frame: sync first, then the nonce MSB first.
  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [31:0] n,
                                            input logic [7:0]  sync);
    logic [7:0] b;
    case (idx)
      3'd0:    b = sync;
      3'd1:    b = n[31:24];
      3'd2:    b = n[23:16];
      3'd3:    b = n[15:8];
      default: b = n[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/nonce_fifo2.sv
// Two-entry synchronous FIFO. A push into a full FIFO is taken only when a
// pop happens on the same cycle; occupancy then stays the same.
module nonce_fifo2 #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty,
  output logic         ready
);

  logic [W-1:0] mem [2];
  logic         rd_ptr, wr_ptr;
  logic [1:0]   count, count_n;
  logic         full_q;
  logic         rd_en, wr_en;

  assign empty    = (count == 2'd0);
  assign rd_en    = pop && !empty;
  assign ready    = !full_q || rd_en;
  assign wr_en    = push && ready;
  assign count_n  = count + {1'b0, wr_en} - {1'b0, rd_en};
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      full_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= ~wr_ptr;
      if (rd_en) rd_ptr <= ~rd_ptr;
      count  <= count_n;
      full_q <= (count_n == 2'd2);
    end
  end

  // Storage needs no reset; the pointers and count qualify it.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/nonce_report_tx.sv
// Golden-nonce reporter: buffers nonces in a 2-entry FIFO and sends each as
// a 5-byte 8N1 UART frame (sync byte then nonce MSB first) on tx.
module nonce_report_tx
  import miner_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        nonce_valid,
  input  logic [31:0] nonce,
  output logic        nonce_ready,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  drop_count
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BYTE = 3'(FRAME_BYTES - 1);

  tx_state_e     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [2:0]    byte_idx, byte_n;
  logic [31:0]   nonce_q, nonce_n;
  logic          tx_q, tx_n;
  logic [7:0]    drop_q;
  logic [7:0]    cur_byte;
  logic          pop, bit_end;
  logic          fifo_empty, fifo_ready;
  logic [31:0]   fifo_data;

  nonce_fifo2 #(.W(32)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (nonce_valid),
    .push_data (nonce),
    .pop       (pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .ready     (fifo_ready)
  );

  assign bit_end     = (cnt == CNT_MAX);
  assign nonce_ready = fifo_ready;
  assign tx          = tx_q;
  assign busy        = (state != ST_IDLE) || !fifo_empty;
  assign drop_count  = drop_q;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CW'(1);
    bit_n    = bit_idx;
    byte_n   = byte_idx;
    nonce_n  = nonce_q;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          nonce_n = fifo_data;
          byte_n  = 3'd0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_n   = '0;
          bit_n   = 3'd0;
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) state_n = ST_STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (byte_idx != LAST_BYTE) begin
            byte_n  = byte_idx + 3'd1;
            state_n = ST_START;
          end else if (!fifo_empty) begin
            // Chain straight into the next frame with no idle bit time.
            pop     = 1'b1;
            nonce_n = fifo_data;
            byte_n  = 3'd0;
            state_n = ST_START;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // tx is registered, so its next value follows the next state.
    cur_byte = frame_byte(byte_n, nonce_n, SYNC_BYTE);
    case (state_n)
      ST_START: tx_n = 1'b0;
      ST_DATA:  tx_n = cur_byte[bit_n];
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 3'd0;
      nonce_q  <= '0;
      tx_q     <= 1'b1;
      drop_q   <= 8'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      nonce_q  <= nonce_n;
      tx_q     <= tx_n;
      if (nonce_valid && !fifo_ready && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_nonce_report_tx.sv
// Directed bench for nonce_report_tx: independent UART receivers decode each
// frame, and per-scenario tasks compare against hand-computed frames.
module tb_nonce_report_tx;

  typedef struct {
    logic [39:0] data;
    bit          ok;
    int          start;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst, nv, ready, tx, busy;
  logic [31:0] nd;
  logic [7:0]  dc;
  logic        rst2, nv2, ready2, tx2, busy2;
  logic [31:0] nd2;
  logic [7:0]  dc2;

  int     cyc = 0;
  int     total = 0;
  int     bad = 0;
  frame_t q0[$];
  frame_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nonce_report_tx #(.CLKS_PER_BIT(4)) dut (
    .clock(clk), .reset(rst), .nonce_valid(nv), .nonce(nd),
    .nonce_ready(ready), .tx(tx), .busy(busy), .drop_count(dc)
  );

  nonce_report_tx #(.CLKS_PER_BIT(2), .SYNC_BYTE(8'h3C)) dut2 (
    .clock(clk), .reset(rst2), .nonce_valid(nv2), .nonce(nd2),
    .nonce_ready(ready2), .tx(tx2), .busy(busy2), .drop_count(dc2)
  );

  // Mid-bit sampling UART receiver; one per DUT.
  task automatic mon(input int which, input int cpb);
    forever begin
      @(negedge clk);
      if (((which == 0) ? tx : tx2) === 1'b0) begin
        frame_t f;
        int     pos;
        logic   b;
        f.start = cyc;
        f.ok    = 1'b1;
        f.data  = '0;
        pos     = 0;
        for (int k = 0; k < 50; k++) begin
          int tgt;
          tgt = k * cpb + cpb / 2;
          repeat (tgt - pos) @(negedge clk);
          pos = tgt;
          b = (which == 0) ? tx : tx2;
          if (k % 10 == 0) begin
            if (b !== 1'b0) f.ok = 1'b0;
          end else if (k % 10 == 9) begin
            if (b !== 1'b1) f.ok = 1'b0;
          end else begin
            f.data[32 - 8 * (k / 10) + (k % 10 - 1)] = b;
          end
        end
        if (which == 0) q0.push_back(f);
        else            q1.push_back(f);
        repeat (50 * cpb - pos - 1) @(negedge clk);
      end
    end
  endtask

  initial mon(0, 4);
  initial mon(1, 2);

  task automatic test_reset;
    rst = 1'b1; rst2 = 1'b1;
    nv = 1'b0; nd = '0; nv2 = 1'b0; nd2 = '0;
    @(negedge clk);
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || dc !== 8'd0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL reset: tx=%b busy=%b drop=%0d ready=%b want 1 0 0 1", tx, busy, dc, ready);
    end
    total++;
    if (tx2 !== 1'b1 || busy2 !== 1'b0 || dc2 !== 8'd0 || ready2 !== 1'b1) begin
      bad++;
      $display("FAIL reset2: tx=%b busy=%b drop=%0d ready=%b want 1 0 0 1", tx2, busy2, dc2, ready2);
    end
    @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single;
    int cp, t;
    q0.delete();
    nv = 1'b1; nd = 32'hDEADBEEF;
    @(negedge clk);
    nv = 1'b0;
    cp = cyc;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL single_busy_rise: got %b want 1", busy);
    end
    t = 0;
    while (q0.size() < 1 && t < 1000) begin @(negedge clk); t++; end
    total++;
    if (q0.size() < 1) begin
      bad++; $display("FAIL single_timeout: frames %0d want 1", q0.size()); return;
    end
    total++;
    if (q0[0].data !== 40'hA5DEADBEEF || !q0[0].ok) begin
      bad++; $display("FAIL single_frame: got %h ok=%0d want a5deadbeef ok=1", q0[0].data, q0[0].ok);
    end
    total++;
    if (q0[0].start != cp + 1) begin
      bad++; $display("FAIL single_latency: tx fell at %0d want %0d", q0[0].start, cp + 1);
    end
    while (cyc < q0[0].start + 199) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL single_busy_last: got %b want 1", busy);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      bad++; $display("FAIL single_end: busy=%b tx=%b want 0 1", busy, tx);
    end
  endtask

  task automatic test_burst;
    int t;
    q0.delete();
    repeat (3) @(negedge clk);
    nv = 1'b1; nd = 32'h11111111;
    @(negedge clk); nd = 32'h22222222;
    @(negedge clk); nd = 32'h33333333;
    @(negedge clk); nd = 32'h44444444;
    #1;
    total++;
    if (ready !== 1'b0) begin
      bad++; $display("FAIL burst_ready_full: got %b want 0", ready);
    end
    @(negedge clk);
    nv = 1'b0;
    total++;
    if (dc !== 8'd1) begin
      bad++; $display("FAIL burst_drop: got %0d want 1", dc);
    end
    t = 0;
    while (q0.size() < 3 && t < 1500) begin @(negedge clk); t++; end
    total++;
    if (q0.size() < 3) begin
      bad++; $display("FAIL burst_timeout: frames %0d want 3", q0.size()); return;
    end
    total++;
    if (q0[0].data !== 40'hA511111111 || q0[1].data !== 40'hA522222222 ||
        q0[2].data !== 40'hA533333333 || !q0[0].ok || !q0[1].ok || !q0[2].ok) begin
      bad++;
      $display("FAIL burst_frames: got %h %h %h want a511111111 a522222222 a533333333",
               q0[0].data, q0[1].data, q0[2].data);
    end
    total++;
    if (q0[1].start != q0[0].start + 200 || q0[2].start != q0[1].start + 200) begin
      bad++;
      $display("FAIL burst_gap: starts %0d %0d %0d want spacing 200",
               q0[0].start, q0[1].start, q0[2].start);
    end
  endtask

  task automatic test_pop_push;
    int cp, s, t;
    q0.delete();
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL pp_idle: busy=%b want 0", busy);
    end
    nv = 1'b1; nd = 32'h66666666;
    @(negedge clk); cp = cyc; nd = 32'h77777777;
    @(negedge clk); nd = 32'h99999999;
    @(negedge clk); nv = 1'b0;
    s = cp + 1;
    while (cyc < s + 198) @(negedge clk);
    total++;
    if (ready !== 1'b0) begin
      bad++; $display("FAIL pp_full: ready=%b want 0", ready);
    end
    @(negedge clk);
    nv = 1'b1; nd = 32'h55555555;
    #1;
    total++;
    if (ready !== 1'b1) begin
      bad++; $display("FAIL pp_ready_on_pop: ready=%b want 1", ready);
    end
    @(negedge clk);
    nv = 1'b0;
    total++;
    if (dc !== 8'd1) begin
      bad++; $display("FAIL pp_drop: got %0d want 1", dc);
    end
    t = 0;
    while (q0.size() < 4 && t < 2000) begin @(negedge clk); t++; end
    total++;
    if (q0.size() < 4) begin
      bad++; $display("FAIL pp_timeout: frames %0d want 4", q0.size()); return;
    end
    total++;
    if (q0[1].data !== 40'hA577777777 || q0[2].data !== 40'hA599999999 ||
        q0[3].data !== 40'hA555555555 || !q0[3].ok) begin
      bad++;
      $display("FAIL pp_order: got %h %h %h want a577777777 a599999999 a555555555",
               q0[1].data, q0[2].data, q0[3].data);
    end
    total++;
    if (q0[0].start != s || q0[3].start != s + 600) begin
      bad++; $display("FAIL pp_timing: starts %0d %0d want %0d %0d", q0[0].start, q0[3].start, s, s + 600);
    end
  endtask

  task automatic test_reset_mid;
    int cp, s, t;
    repeat (5) @(negedge clk);
    nv = 1'b1; nd = 32'h12345678;
    @(negedge clk); nv = 1'b0; cp = cyc;
    s = cp + 1;
    while (cyc < s + 100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || dc !== 8'd0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset: tx=%b busy=%b drop=%0d ready=%b want 1 0 0 1", tx, busy, dc, ready);
    end
    rst = 1'b0;
    repeat (250) @(negedge clk);
    q0.delete();
    nv = 1'b1; nd = 32'h88888888;
    @(negedge clk); nv = 1'b0;
    t = 0;
    while (q0.size() < 1 && t < 1000) begin @(negedge clk); t++; end
    total++;
    if (q0.size() < 1) begin
      bad++; $display("FAIL midreset_timeout: frames %0d want 1", q0.size()); return;
    end
    total++;
    if (q0[0].data !== 40'hA588888888 || !q0[0].ok) begin
      bad++; $display("FAIL midreset_frame: got %h ok=%0d want a588888888 ok=1", q0[0].data, q0[0].ok);
    end
  endtask

  task automatic test_saturate;
    bit   wrapped;
    logic [7:0] prev;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    wrapped = 1'b0;
    prev = 8'd0;
    for (int i = 0; i < 303; i++) begin
      @(negedge clk);
      if (dc < prev) wrapped = 1'b1;
      prev = dc;
      if (i == 103) begin
        total++;
        if (dc !== 8'd100) begin
          bad++; $display("FAIL sat_mid: got %0d want 100", dc);
        end
      end
      nv = 1'b1; nd = 32'h90000000 + i;
    end
    @(negedge clk);
    nv = 1'b0;
    if (dc < prev) wrapped = 1'b1;
    total++;
    if (dc !== 8'd255 || wrapped) begin
      bad++; $display("FAIL sat_end: got %0d wrapped=%0d want 255 wrapped=0", dc, wrapped);
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (250) @(negedge clk);
  endtask

  task automatic test_small;
    int cp, t;
    q1.delete();
    nv2 = 1'b1; nd2 = 32'h00000000;
    @(negedge clk); nv2 = 1'b0; cp = cyc;
    total++;
    if (busy2 !== 1'b1) begin
      bad++; $display("FAIL small_busy_rise: got %b want 1", busy2);
    end
    t = 0;
    while (q1.size() < 1 && t < 500) begin @(negedge clk); t++; end
    total++;
    if (q1.size() < 1) begin
      bad++; $display("FAIL small_timeout: frames %0d want 1", q1.size()); return;
    end
    total++;
    if (q1[0].data !== 40'h3C00000000 || !q1[0].ok || q1[0].start != cp + 1) begin
      bad++;
      $display("FAIL small_frame: got %h ok=%0d start=%0d want 3c00000000 ok=1 start=%0d",
               q1[0].data, q1[0].ok, q1[0].start, cp + 1);
    end
    while (cyc < q1[0].start + 100) @(negedge clk);
    total++;
    if (busy2 !== 1'b0 || tx2 !== 1'b1) begin
      bad++; $display("FAIL small_end: busy=%b tx=%b want 0 1", busy2, tx2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_pop_push();
    test_reset_mid();
    test_saturate();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
